// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shifter: op encodings, FSM states
// and default datapath sizes.
package shift_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROL = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the execute stage and the shift sequencer.
interface shift_sequencer_if
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt;
    logic               flush;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, op, operand, shamt, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand, shamt, flush,
        output busy, done, result
    );
endinterface

// File: rtl/shift_step.sv
// One-bit shift/rotate step; the sequencer applies it once per SHIFT cycle.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  op_e              op,
    output logic [WIDTH-1:0] stepped
);
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_bits
            assign shl[gi]   = value[gi-1];
            assign shr[gi-1] = value[gi];
        end
    endgenerate

    // Only the vacated end bit depends on the op.
    assign shl[0]       = (op == OP_ROL) ? value[WIDTH-1] : 1'b0;
    assign shr[WIDTH-1] = (op == OP_SRA) ? value[WIDTH-1] : 1'b0;

    assign stepped = (op == OP_SLL || op == OP_ROL) ? shl : shr;
endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable shifter: applies a single one-bit step shamt times,
// trading latency (shamt+2 cycles) for area against a barrel shifter.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  bus
);
    state_e             state_reg, state_next;
    logic [WIDTH-1:0]   work_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [SHAMT_W-1:0] count_reg;
    op_e                op_reg;
    logic [WIDTH-1:0]   work_stepped;
    logic               accept;
    logic               step_en;
    logic               finish;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value   (work_reg),
        .op      (op_reg),
        .stepped (work_stepped)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (count_reg != '0) begin
                    step_en = 1'b1;
                end else begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            work_reg   <= '0;
            result_reg <= '0;
            count_reg  <= '0;
            op_reg     <= OP_SLL;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                work_reg  <= bus.operand;
                count_reg <= bus.shamt;
                op_reg    <= op_e'(bus.op);
            end
            if (step_en) begin
                work_reg  <= work_stepped;
                count_reg <= count_reg - SHAMT_W'(1);
            end
            // Result is committed only on the SHIFT->DONE transition.
            if (finish) begin
                result_reg <= work_reg;
            end
        end
    end

    assign bus.busy   = (state_reg != IDLE);
    assign bus.done   = (state_reg == DONE) && !bus.flush;
    assign bus.result = result_reg;
endmodule
